// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared default widths and pointer-width helper for the RAM-backed FIFO
package dp_ram_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/dp_ram_async_read.sv
// dp_ram_async_read: dual-port RAM, synchronous writes on both ports, asynchronous port-B read
module dp_ram_async_read #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end
  assign dout_b = mem[addr_b];
endmodule

// File: rtl/dp_ram_fifo.sv
// dp_ram_fifo: show-ahead FIFO over an async-read dual-port RAM, extra-MSB pointers
module dp_ram_fifo
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] AF = PW'(AF_THRESH);
  logic [PW-1:0] wr_ptr, rd_ptr, cnt;
  logic push, pop;
  assign empty       = wr_ptr == rd_ptr;
  assign full        = wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0] && wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH];
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign almost_full = cnt >= AF;
  assign count       = cnt;
  // flush suppresses the RAM write as well as the pointer updates
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + PW'(push) - PW'(pop);
    end
  end
  dp_ram_async_read #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk    (clk),
    .we_a   (push),
    .addr_a (wr_ptr[ADDR_WIDTH-1:0]),
    .din_a  (in_data),
    .we_b   (1'b0),
    .addr_b (rd_ptr[ADDR_WIDTH-1:0]),
    .din_b  ({DATA_WIDTH{1'b0}}),
    .dout_b (out_data)
  );
endmodule

// File: tb/tb_dp_ram_fifo.sv
// tb_dp_ram_fifo: directed stimulus with a queue reference model checked every cycle
module tb_dp_ram_fifo;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0, out_data;
  logic in_ready, out_valid, full, empty, almost_full;
  logic [6:0] count;
  int checks = 0, failures = 0;
  logic [7:0] q[$];

  dp_ram_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a FIFO of at most 64 words, flush and reset discard everything
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) q.delete();
    else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && q.size() + (out_ready && q.size() > 0 ? 1 : 0) < 65 && !(q.size() == 64 && !out_ready) && !(q.size() == 64)) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == 64));
    chk("m_af", 32'(almost_full), 32'(q.size() >= 60));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() != 64));
    chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("m_out_data", 32'(out_data), 32'(q[0]));
  end

  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  initial begin
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 8'hAA, 0, 0);
    chk("one_valid", 32'(out_valid), 1);
    chk("one_data", 32'(out_data), 32'hAA);
    chk("one_count", 32'(count), 1);
    cyc(0, 0, 1, 0);
    chk("one_pop_empty", 32'(empty), 1);
    for (int i = 0; i < 64; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 58) chk("af_at59", 32'(almost_full), 0);
      if (i == 59) chk("af_at60", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_count", 32'(count), 64);
    cyc(1, 8'hFF, 0, 0);
    chk("overflow_count", 32'(count), 64);
    for (int i = 0; i < 64; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      cyc(0, 0, 1, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(0, 0, 1, 0);
    chk("underflow_count", 32'(count), 0);
    for (int i = 0; i < 100; i++) begin
      cyc(1, 8'(i + 8'h40), 0, 0);
      cyc(1, 8'(i + 8'h80), 0, 0);
      chk("wrap_data0", 32'(out_data), 32'(8'(i + 8'h40)));
      cyc(0, 0, 1, 0);
      chk("wrap_data1", 32'(out_data), 32'(8'(i + 8'h80)));
      cyc(0, 0, 1, 0);
    end
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'h11, 1, 0);
    chk("simul_count", 32'(count), 5);
    for (int i = 0; i < 4; i++) begin
      chk("simul_order", 32'(out_data), 32'(i + 2));
      cyc(0, 0, 1, 0);
    end
    chk("simul_fifth", 32'(out_data), 32'h11);
    cyc(0, 0, 1, 0);
    chk("simul_empty", 32'(empty), 1);
    for (int i = 0; i < 10; i++) cyc(1, 8'(i + 8'h20), 0, 0);
    chk("pre_flush_count", 32'(count), 10);
    cyc(1, 8'h77, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    cyc(1, 8'h33, 0, 0);
    chk("post_flush_count", 32'(count), 1);
    chk("post_flush_data", 32'(out_data), 32'h33);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1, 8'(i + 8'h60), 0, 0);
    chk("pre_rst_count", 32'(count), 7);
    #2 rst_n = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(negedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 8'h5A, 0, 0);
    cyc(1, 8'h5B, 0, 0);
    chk("post_rst_first", 32'(out_data), 32'h5A);
    cyc(0, 0, 1, 0);
    chk("post_rst_second", 32'(out_data), 32'h5B);
    cyc(0, 0, 1, 0);
    chk("post_rst_empty", 32'(empty), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
